// File: rtl/cpu.sv
// Single-cycle MIPS-subset core: PC, instruction ROM, 32x32 register file, decode and ALU.
// Optional: define CPU_MUL_EN to enable the funct 0x18 multiply; otherwise it decodes as a NOP.

module cpu_pc (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [31:0] pc_o
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)       pc_o <= 32'd0;
    else if (start_i) pc_o <= pc_o + 32'd4;
  end
endmodule

module cpu_imem #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic [AW-1:0] addr_i,
  output logic [31:0]   instr_o
);
  // Contents are loaded from outside the design; there is no write port.
  logic [31:0] memory [0:DEPTH-1];

  assign instr_o = memory[addr_i];
endmodule

module cpu_regfile (
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [4:0]  ra1_i,
  input  logic [4:0]  ra2_i,
  input  logic [4:0]  wa_i,
  input  logic [31:0] wd_i,
  output logic [31:0] rd1_o,
  output logic [31:0] rd2_o
);
  logic [31:0] register [0:31];

  // No reset: contents survive a core reset.
  always_ff @(posedge clk_i) begin
    if (we_i && (wa_i != 5'd0)) register[wa_i] <= wd_i;
  end

  assign rd1_o = (ra1_i == 5'd0) ? 32'd0 : register[ra1_i];
  assign rd2_o = (ra2_i == 5'd0) ? 32'd0 : register[ra2_i];
endmodule

module cpu #(
  parameter int IMEM_DEPTH = 256
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i
);
  localparam int AW = $clog2(IMEM_DEPTH);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_MUL   = 6'h18;

  logic [31:0] w_pc;
  logic [31:0] w_instr;
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [31:0] w_imm_ext;
  logic [31:0] w_rs_data;
  logic [31:0] w_rt_data;
  logic        w_wr_en;
  logic [4:0]  w_wr_addr;
  logic [31:0] w_wr_data;
  logic        w_unused_pc;

  cpu_pc PC (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .pc_o    (w_pc)
  );

  cpu_imem #(
    .DEPTH (IMEM_DEPTH),
    .AW    (AW)
  ) Instruction_Memory (
    .addr_i  (w_pc[AW+1:2]),
    .instr_o (w_instr)
  );

  // Byte offset and upper PC bits play no part in the word fetch.
  assign w_unused_pc = ^{w_pc[31:AW+2], w_pc[1:0]};

  assign w_op      = w_instr[31:26];
  assign w_rs      = w_instr[25:21];
  assign w_rt      = w_instr[20:16];
  assign w_rd      = w_instr[15:11];
  assign w_funct   = w_instr[5:0];
  assign w_imm_ext = {{16{w_instr[15]}}, w_instr[15:0]};

  cpu_regfile Registers (
    .clk_i (clk_i),
    .we_i  (w_wr_en && rst_i && start_i),
    .ra1_i (w_rs),
    .ra2_i (w_rt),
    .wa_i  (w_wr_addr),
    .wd_i  (w_wr_data),
    .rd1_o (w_rs_data),
    .rd2_o (w_rt_data)
  );

  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_addr = w_rd;
    w_wr_data = 32'd0;
    if (w_op == OP_RTYPE) begin
      case (w_funct)
        FN_ADD: begin w_wr_en = 1'b1; w_wr_data = w_rs_data + w_rt_data; end
        FN_SUB: begin w_wr_en = 1'b1; w_wr_data = w_rs_data - w_rt_data; end
        FN_AND: begin w_wr_en = 1'b1; w_wr_data = w_rs_data & w_rt_data; end
        FN_OR:  begin w_wr_en = 1'b1; w_wr_data = w_rs_data | w_rt_data; end
`ifdef CPU_MUL_EN
        FN_MUL: begin w_wr_en = 1'b1; w_wr_data = w_rs_data * w_rt_data; end
`else
        FN_MUL: w_wr_en = 1'b0;
`endif
        default: w_wr_en = 1'b0;
      endcase
    end else if (w_op == OP_ADDI) begin
      w_wr_en   = 1'b1;
      w_wr_addr = w_rt;
      w_wr_data = w_rs_data + w_imm_ext;
    end
  end
endmodule

// File: tb/tb_cpu.sv
// Self-checking bench for cpu: table-driven single-instruction vectors via a scoreboard,
// plus hand sequences for reset/hold, r0/NOP handling, PC wrap and mid-run reset.

module tb_cpu;
  logic clk_i;
  logic rst_i;
  logic start_i;

  int n_checks = 0;
  int n_errors = 0;

`ifdef CPU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  cpu #(.IMEM_DEPTH(256)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  dst;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [4:0]  dst;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic vec_t mk(input string name, input logic [31:0] instr, input logic [4:0] dst,
                              input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    vec_t v;
    v.name = name; v.instr = instr; v.dst = dst; v.a = a; v.b = b; v.exp = exp;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a falling edge; runs n rising edges with start_i high, returns at a falling edge.
  task automatic step(input int n);
    start_i = 1'b1;
    repeat (n) @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic do_reset();
    start_i = 1'b0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    rst_i   = 1'b1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = 32'd0;
  endtask

  initial begin
    sb_t e;
    int  bad;
    logic [31:0] DB;
    DB = 32'hDEADBEEF;

    rst_i   = 1'b0;
    start_i = 1'b0;
    clear_mem();
    for (int i = 0; i < 32; i++) dut.Registers.register[i] = 32'd0;
    dut.Instruction_Memory.memory[0] = itype(6'h08, 5'd8, 5'd0, 16'd10);
    dut.Instruction_Memory.memory[1] = itype(6'h08, 5'd9, 5'd0, 16'hFFFD);

    // Reset and hold
    #3;
    check("reset_pc", dut.PC.pc_o, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("hold_pc", dut.PC.pc_o, 32'd0);
    end
    check("hold_no_write_r8", dut.Registers.register[8], 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step(1);
      check("run_pc", dut.PC.pc_o, 32'(4 * i));
    end
    check("addi_pos_r8", dut.Registers.register[8], 32'd10);
    check("addi_neg_r9", dut.Registers.register[9], 32'hFFFFFFFD);

    // Single-instruction vectors: r8=a, r9=b, destination pre-filled with a marker
    vecs.push_back(mk("add",      rtype(5'd10, 5'd8, 5'd9, 6'h20), 5'd10, 32'd10, 32'd3, 32'd13));
    vecs.push_back(mk("sub",      rtype(5'd11, 5'd8, 5'd9, 6'h22), 5'd11, 32'd10, 32'd3, 32'd7));
    vecs.push_back(mk("and",      rtype(5'd12, 5'd8, 5'd9, 6'h24), 5'd12, 32'd10, 32'd3, 32'd2));
    vecs.push_back(mk("or",       rtype(5'd13, 5'd8, 5'd9, 6'h25), 5'd13, 32'd10, 32'd3, 32'd11));
    vecs.push_back(mk("add_wrap", rtype(5'd10, 5'd8, 5'd9, 6'h20), 5'd10, 32'hFFFFFFFF, 32'd1, 32'd0));
    vecs.push_back(mk("sub_neg",  rtype(5'd11, 5'd8, 5'd9, 6'h22), 5'd11, 32'd3, 32'd10, 32'hFFFFFFF9));
    vecs.push_back(mk("addi_min", itype(6'h08, 5'd10, 5'd8, 16'h8000), 5'd10, 32'd0, 32'd0, 32'hFFFF8000));
    vecs.push_back(mk("addi_max", itype(6'h08, 5'd10, 5'd8, 16'h7FFF), 5'd10, 32'd1, 32'd0, 32'h00008000));
    vecs.push_back(mk("mul",      rtype(5'd14, 5'd8, 5'd9, 6'h18), 5'd14, 32'd7, 32'd6,
                      MUL_EN ? 32'd42 : DB));
    vecs.push_back(mk("mul_low",  rtype(5'd14, 5'd8, 5'd9, 6'h18), 5'd14, 32'h00010003, 32'h00010000,
                      MUL_EN ? 32'h00030000 : DB));
    vecs.push_back(mk("bad_funct", rtype(5'd10, 5'd8, 5'd9, 6'h21), 5'd10, 32'd1, 32'd2, DB));
    vecs.push_back(mk("bad_op",   {6'h3F, 5'd8, 5'd10, 16'h0001}, 5'd10, 32'd1, 32'd2, DB));

    for (int i = 0; i < vecs.size(); i++) begin
      do_reset();
      dut.Registers.register[8]          = vecs[i].a;
      dut.Registers.register[9]          = vecs[i].b;
      dut.Registers.register[vecs[i].dst] = DB;
      dut.Instruction_Memory.memory[0]   = vecs[i].instr;
      sb.push_back('{name: vecs[i].name, dst: vecs[i].dst, exp: vecs[i].exp});
      step(1);
      e = sb.pop_front();
      check(e.name, dut.Registers.register[e.dst], e.exp);
      check({e.name, "_pc"}, dut.PC.pc_o, 32'd4);
    end

    // r0 writes discarded, NOPs leave registers alone, r0 reads as zero
    do_reset();
    clear_mem();
    dut.Registers.register[0] = 32'd0;
    for (int i = 1; i < 32; i++) dut.Registers.register[i] = 32'h1000 + i;
    dut.Instruction_Memory.memory[0] = itype(6'h08, 5'd0, 5'd0, 16'd5);
    dut.Instruction_Memory.memory[1] = 32'd0;
    dut.Instruction_Memory.memory[2] = {6'h3F, 26'h3FFFFFF};
    dut.Instruction_Memory.memory[3] = rtype(5'd10, 5'd0, 5'd0, 6'h20);
    step(1);
    check("r0_write_discarded", dut.Registers.register[0], 32'd0);
    check("nop_pc1", dut.PC.pc_o, 32'd4);
    step(1);
    check("nop_pc2", dut.PC.pc_o, 32'd8);
    step(1);
    check("nop_pc3", dut.PC.pc_o, 32'd12);
    bad = 0;
    for (int i = 1; i < 32; i++)
      if (dut.Registers.register[i] !== 32'(32'h1000 + i)) bad++;
    check("nop_regs_unchanged", 32'(bad), 32'd0);
    dut.Registers.register[0] = 32'h77;
    step(1);
    check("r0_reads_zero", dut.Registers.register[10], 32'd0);

    // PC wrap over 256 words and asynchronous reset mid-run
    do_reset();
    clear_mem();
    dut.Instruction_Memory.memory[0] = itype(6'h08, 5'd20, 5'd20, 16'd1);
    dut.Registers.register[20] = 32'd0;
    step(256);
    check("wrap_pc_1024", dut.PC.pc_o, 32'd1024);
    check("wrap_r20_first", dut.Registers.register[20], 32'd1);
    step(44);
    check("wrap_pc_1200", dut.PC.pc_o, 32'd1200);
    check("wrap_r20_second", dut.Registers.register[20], 32'd2);
    start_i = 1'b1;
    #2;
    rst_i = 1'b0;
    #1;
    check("midrun_reset_pc", dut.PC.pc_o, 32'd0);
    check("midrun_reset_regs", dut.Registers.register[20], 32'd2);
    @(negedge clk_i);
    check("reset_held_pc", dut.PC.pc_o, 32'd0);
    check("reset_held_regs", dut.Registers.register[20], 32'd2);
    rst_i = 1'b1;
    step(1);
    check("restart_pc", dut.PC.pc_o, 32'd4);
    check("restart_r20", dut.Registers.register[20], 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
